// File: rtl/uart_packet_parser_pkg.sv
// Shared types and constants for the UART packet parser: FSM states, error codes,
// the default start-of-frame marker and an index-width helper.
package uart_packet_parser_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4,
        S_HOLD    = 3'd5
    } state_e;

    localparam logic [1:0] ERR_CHK = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam logic [1:0] ERR_OVR = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hAA;

    // Never returns 0 so that a depth of 1 still yields a legal one-bit index.
    function automatic int unsigned index_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_payload_buf.sv
// Payload register file: synchronous write port, asynchronous read port.
module uart_payload_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_packet_parser.sv
// Frames the UART byte stream into SOF/CMD/LEN/payload/XOR packets, holds checked
// frames for the consumer and reports checksum, length, timeout and overrun errors.
module uart_packet_parser
    import uart_packet_parser_pkg::*;
#(
    parameter int unsigned          DATA_BITS      = 8,
    parameter int unsigned          MAX_PAYLOAD    = 16,
    parameter logic [DATA_BITS-1:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int unsigned          TIMEOUT_CYCLES = 500000
) (
    input  logic                                 clk_50MHz,
    input  logic                                 reset,
    input  logic [DATA_BITS-1:0]                 rx_data,
    input  logic                                 rx_valid,
    output logic                                 frame_valid,
    output logic [DATA_BITS-1:0]                 frame_cmd,
    output logic [DATA_BITS-1:0]                 frame_len,
    output logic                                 frame_pending,
    input  logic                                 frame_ack,
    input  logic [index_width(MAX_PAYLOAD)-1:0]  rd_addr,
    output logic [DATA_BITS-1:0]                 rd_data,
    output logic                                 err_valid,
    output logic [1:0]                           err_code
);

    localparam int unsigned          AW       = index_width(MAX_PAYLOAD);
    localparam int unsigned          TW       = index_width(TIMEOUT_CYCLES);
    localparam logic [DATA_BITS-1:0] MAX_LEN  = DATA_BITS'(MAX_PAYLOAD);
    localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] cmd_q, cmd_d;
    logic [DATA_BITS-1:0] len_q, len_d;
    logic [DATA_BITS-1:0] chk_q, chk_d;
    logic [DATA_BITS-1:0] idx_q, idx_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [DATA_BITS-1:0] frame_cmd_q, frame_cmd_d;
    logic [DATA_BITS-1:0] frame_len_q, frame_len_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 err_valid_q, err_valid_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 buf_we;
    logic [AW-1:0]        buf_waddr;
    logic                 in_frame;

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cmd_q         <= '0;
            len_q         <= '0;
            chk_q         <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            frame_cmd_q   <= '0;
            frame_len_q   <= '0;
            frame_valid_q <= 1'b0;
            err_valid_q   <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            len_q         <= len_d;
            chk_q         <= chk_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_len_q   <= frame_len_d;
            frame_valid_q <= frame_valid_d;
            err_valid_q   <= err_valid_d;
            err_code_q    <= err_code_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        len_d         = len_q;
        chk_d         = chk_q;
        idx_d         = idx_q;
        tmo_d         = '0;
        frame_cmd_d   = frame_cmd_q;
        frame_len_d   = frame_len_q;
        frame_valid_d = 1'b0;
        err_valid_d   = 1'b0;
        err_code_d    = err_code_q;
        buf_we        = 1'b0;
        buf_waddr     = idx_q[AW-1:0];
        in_frame      = state_q inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK};

        case (state_q)
            S_IDLE: begin
                if (rx_valid && (rx_data == SOF_BYTE)) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (rx_valid) begin
                    cmd_d   = rx_data;
                    chk_d   = rx_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    chk_d = chk_q ^ rx_data;
                    if (rx_data > MAX_LEN) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_IDLE;
                    end else begin
                        len_d   = rx_data;
                        idx_d   = '0;
                        state_d = (rx_data == '0) ? S_CHK : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ rx_data;
                    idx_d  = idx_q + DATA_BITS'(1);
                    if (idx_q == len_q - DATA_BITS'(1)) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        frame_valid_d = 1'b1;
                        frame_cmd_d   = cmd_q;
                        frame_len_d   = len_q;
                        state_d       = S_HOLD;
                    end else begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // With an ack, the same-cycle byte is judged as if already back in IDLE.
                if (frame_ack) begin
                    state_d = (rx_valid && (rx_data == SOF_BYTE)) ? S_CMD : S_IDLE;
                end else if (rx_valid) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_OVR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An arriving byte always beats a timeout hit in the same cycle.
        if (in_frame && !rx_valid) begin
            if (tmo_q == TMO_LAST) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_TMO;
                state_d     = S_IDLE;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    uart_payload_buf #(
        .DEPTH (MAX_PAYLOAD),
        .WIDTH (DATA_BITS),
        .AW    (AW)
    ) u_payload_buf (
        .clk_i   (clk_50MHz),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (rx_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign frame_valid   = frame_valid_q;
    assign frame_cmd     = frame_cmd_q;
    assign frame_len     = frame_len_q;
    assign frame_pending = (state_q == S_HOLD);
    assign err_valid     = err_valid_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed bench for uart_packet_parser with a byte-stream reference model that
// is compared against the DUT every cycle, plus literal spot checks.
module tb_uart_packet_parser;

    localparam int         MAXP = 16;
    localparam int         TMO  = 1000;
    localparam logic [7:0] SOF  = 8'hAA;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [7:0] frame_len;
    logic       frame_pending;
    logic       frame_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_valid;
    logic [1:0] err_code;

    int checks = 0;
    int passes = 0;
    bit started = 0;

    uart_packet_parser #(
        .DATA_BITS      (8),
        .MAX_PAYLOAD    (MAXP),
        .SOF_BYTE       (SOF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_50MHz     (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .frame_valid   (frame_valid),
        .frame_cmd     (frame_cmd),
        .frame_len     (frame_len),
        .frame_pending (frame_pending),
        .frame_ack     (frame_ack),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .err_valid     (err_valid),
        .err_code      (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks the frame as a list of bytes after SOF and decides
    // completion purely from the byte count implied by the LEN byte.
    logic [7:0] frameBytes[$];
    bit         inFrame    = 0;
    bit         holding    = 0;
    int         gap        = 0;
    logic       expValid   = 0;
    logic       expPending = 0;
    logic       expErr     = 0;
    logic [1:0] expErrCode = 0;
    logic [7:0] expCmd     = 0;
    logic [7:0] expLen     = 0;
    logic [7:0] expPayload [MAXP];

    task automatic modelError(input logic [1:0] code);
        expErr     = 1'b1;
        expErrCode = code;
        inFrame    = 0;
    endtask

    task automatic modelStart();
        inFrame = 1;
        gap     = 0;
        frameBytes.delete();
    endtask

    always @(posedge clk) begin
        int         n;
        logic [7:0] x;
        expValid = 1'b0;
        expErr   = 1'b0;
        if (reset) begin
            inFrame    = 0;
            holding    = 0;
            gap        = 0;
            frameBytes.delete();
            expCmd     = 0;
            expLen     = 0;
            expErrCode = 0;
        end else if (holding) begin
            if (frame_ack) begin
                holding = 0;
                if (rx_valid && rx_data == SOF) modelStart();
            end else if (rx_valid) begin
                modelError(2'd3);
            end
        end else if (!inFrame) begin
            if (rx_valid && rx_data == SOF) modelStart();
        end else if (rx_valid) begin
            frameBytes.push_back(rx_data);
            gap = 0;
            n = frameBytes.size();
            if (n == 2 && frameBytes[1] > MAXP) begin
                modelError(2'd1);
            end else if (n >= 2 && n == int'(frameBytes[1]) + 3) begin
                x = 8'h00;
                for (int i = 0; i < n - 1; i++) x = x ^ frameBytes[i];
                if (x == frameBytes[n-1]) begin
                    inFrame  = 0;
                    holding  = 1;
                    expValid = 1'b1;
                    expCmd   = frameBytes[0];
                    expLen   = frameBytes[1];
                    for (int i = 0; i < int'(expLen); i++) expPayload[i] = frameBytes[2+i];
                end else begin
                    modelError(2'd0);
                end
            end
        end else begin
            gap++;
            if (gap == TMO) modelError(2'd2);
        end
        expPending = holding;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        else
            passes++;
    endtask

    always @(negedge clk) begin
        #2;
        if (started) begin
            checkOutput("frame_valid", frame_valid, expValid);
            checkOutput("frame_pending", frame_pending, expPending);
            checkOutput("frame_cmd", frame_cmd, expCmd);
            checkOutput("frame_len", frame_len, expLen);
            checkOutput("err_valid", err_valid, expErr);
            if (expErr) checkOutput("err_code", err_code, expErrCode);
            if (expPending && rd_addr < expLen)
                checkOutput("rd_data", rd_data, expPayload[rd_addr]);
        end
    end

    logic [7:0] txQueue[$];

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic sendQueue();
        foreach (txQueue[i]) applyStimulus(txQueue[i]);
    endtask

    task automatic ackFrame();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        #1;
        checkOutput("pending_after_ack", frame_pending, 1'b0);
    endtask

    initial begin
        int waited;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        frame_ack = 1'b0;
        rd_addr   = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_frame_valid", frame_valid, 1'b0);
        checkOutput("reset_pending", frame_pending, 1'b0);
        checkOutput("reset_err_valid", err_valid, 1'b0);
        checkOutput("reset_cmd", frame_cmd, 8'h00);
        checkOutput("reset_len", frame_len, 8'h00);
        checkOutput("reset_err_code", err_code, 2'd0);
        reset   = 1'b0;
        started = 1;
        @(negedge clk);

        // Good frame, then overrun while held, then ack racing a new SOF.
        txQueue = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        sendQueue();
        #1;
        checkOutput("good_valid", frame_valid, 1'b1);
        checkOutput("good_cmd", frame_cmd, 8'h01);
        checkOutput("good_len", frame_len, 8'h02);
        checkOutput("good_pending", frame_pending, 1'b1);
        rd_addr = 4'd0; #1;
        checkOutput("good_rd0", rd_data, 8'h10);
        rd_addr = 4'd1; #1;
        checkOutput("good_rd1", rd_data, 8'h20);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("held_pending", frame_pending, 1'b1);
        applyStimulus(8'h42);
        #1;
        checkOutput("ovr_err_valid", err_valid, 1'b1);
        checkOutput("ovr_err_code", err_code, 2'd3);
        checkOutput("ovr_cmd", frame_cmd, 8'h01);
        checkOutput("ovr_len", frame_len, 8'h02);
        rd_addr = 4'd0; #1;
        checkOutput("ovr_rd0", rd_data, 8'h10);
        rd_addr = 4'd1; #1;
        checkOutput("ovr_rd1", rd_data, 8'h20);
        frame_ack = 1'b1;
        applyStimulus(SOF);
        frame_ack = 1'b0;
        txQueue = '{8'h01, 8'h00, 8'h01};
        sendQueue();
        #1;
        checkOutput("race_valid", frame_valid, 1'b1);
        checkOutput("race_cmd", frame_cmd, 8'h01);
        checkOutput("race_len", frame_len, 8'h00);
        ackFrame();

        // Bad checksum followed by a good one-byte frame.
        txQueue = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
        sendQueue();
        #1;
        checkOutput("badchk_err", err_valid, 1'b1);
        checkOutput("badchk_code", err_code, 2'd0);
        checkOutput("badchk_novalid", frame_valid, 1'b0);
        txQueue = '{8'hAA, 8'h03, 8'h01, 8'h7E, 8'h7C};
        sendQueue();
        #1;
        checkOutput("after_bad_valid", frame_valid, 1'b1);
        checkOutput("after_bad_cmd", frame_cmd, 8'h03);
        rd_addr = 4'd0; #1;
        checkOutput("after_bad_rd0", rd_data, 8'h7E);
        ackFrame();

        // Length violation, ignored junk, garbage prefix and zero-length frame.
        txQueue = '{8'hAA, 8'h07, 8'h11};
        sendQueue();
        #1;
        checkOutput("len_err", err_valid, 1'b1);
        checkOutput("len_code", err_code, 2'd1);
        txQueue = '{8'h01, 8'h02, 8'h03, 8'h55, 8'h00, 8'hAA, 8'h05, 8'h00, 8'h05};
        sendQueue();
        #1;
        checkOutput("zero_valid", frame_valid, 1'b1);
        checkOutput("zero_cmd", frame_cmd, 8'h05);
        checkOutput("zero_len", frame_len, 8'h00);
        ackFrame();

        // Timeout exactly TMO cycles after the CMD byte.
        txQueue = '{8'hAA, 8'h01};
        sendQueue();
        waited = 0;
        for (int k = 1; k <= TMO + 100 && waited == 0; k++) begin
            @(negedge clk);
            #1;
            if (err_valid) waited = k;
        end
        checkOutput("tmo_delay", waited, TMO);
        checkOutput("tmo_code", err_code, 2'd2);
        @(negedge clk);

        // A byte on the final cycle of the window wins over the timeout.
        txQueue = '{8'hAA, 8'h01};
        sendQueue();
        repeat (TMO - 1) @(negedge clk);
        txQueue = '{8'h00, 8'h01};
        sendQueue();
        #1;
        checkOutput("tmo_edge_valid", frame_valid, 1'b1);
        checkOutput("tmo_edge_noerr", err_valid, 1'b0);
        ackFrame();

        // Maximum-length frame: payload 0..15, checksum 09^10^0 = 19.
        txQueue = '{8'hAA, 8'h09, 8'h10};
        for (int i = 0; i < MAXP; i++) txQueue.push_back(8'(i));
        txQueue.push_back(8'h19);
        sendQueue();
        #1;
        checkOutput("max_valid", frame_valid, 1'b1);
        checkOutput("max_len", frame_len, 8'h10);
        rd_addr = 4'd15; #1;
        checkOutput("max_rd15", rd_data, 8'h0F);
        ackFrame();

        // Reset in the middle of a payload.
        txQueue = '{8'hAA, 8'h02, 8'h03, 8'h11};
        sendQueue();
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midrst_valid", frame_valid, 1'b0);
        checkOutput("midrst_pending", frame_pending, 1'b0);
        checkOutput("midrst_err", err_valid, 1'b0);
        checkOutput("midrst_cmd", frame_cmd, 8'h00);
        checkOutput("midrst_len", frame_len, 8'h00);
        checkOutput("midrst_code", err_code, 2'd0);
        reset = 1'b0;
        @(negedge clk);
        txQueue = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        sendQueue();
        #1;
        checkOutput("post_rst_valid", frame_valid, 1'b1);
        checkOutput("post_rst_cmd", frame_cmd, 8'h01);
        ackFrame();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
